// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer; optional sticky error flags via UART_RX_ERR_FLAGS_EN
module uart_rx_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    input  logic                  err_clr,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  deser_en,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  par_err_flag,
    output logic                  stp_err_flag
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [PRESCALE_W-1:0] PS_ONE   = PRESCALE_W'(1);
    localparam logic [3:0]            LAST_BIT = 4'(DATA_W - 1);

    state_t                  state, state_nxt;
    logic [PRESCALE_W-1:0]   ps_q;
    logic                    par_en_q;
    logic                    frame_err;
    logic                    bit_end;

    // A prescale below the supported range still wraps edge_cnt, so every phase terminates.
    assign bit_end = (edge_cnt == ps_q - PS_ONE);

    always_comb begin
        state_nxt   = state;
        deser_en    = 1'b0;
        strt_chk_en = (state == START);
        par_chk_en  = (state == PARITY);
        stp_chk_en  = (state == STOP);
        busy        = (state != IDLE);
        dat_samp_en = (state != IDLE);
        case (state)
            IDLE:    if (!rx_in) state_nxt = START;
            START:   if (bit_end) state_nxt = strt_glitch ? IDLE : DATA;
            DATA: begin
                if (bit_end) begin
                    deser_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            ps_q       <= '0;
            par_en_q   <= 1'b0;
            frame_err  <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= 1'b0;
            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                if (!rx_in) begin
                    ps_q      <= prescale;
                    par_en_q  <= par_en;
                    frame_err <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PS_ONE;
            end
            case (state)
                START:  if (bit_end) bit_cnt <= '0;
                DATA:   if (bit_end) bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
                PARITY: if (bit_end) frame_err <= par_err;
                STOP:   if (bit_end) data_valid <= !stp_err && !frame_err;
                default: ;
            endcase
        end
    end

`ifdef UART_RX_ERR_FLAGS_EN
    // Set has priority over err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_err_flag <= 1'b0;
            stp_err_flag <= 1'b0;
        end else begin
            if (state == PARITY && bit_end && par_err) par_err_flag <= 1'b1;
            else if (err_clr)                          par_err_flag <= 1'b0;
            if (state == STOP && bit_end && stp_err)   stp_err_flag <= 1'b1;
            else if (err_clr)                          stp_err_flag <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign par_err_flag   = 1'b0;
    assign stp_err_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst, rx_in, par_en, strt_glitch, par_err, stp_err, err_clr;
    logic [5:0] prescale, edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
    logic       data_valid, busy, par_err_flag, stp_err_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_kind[$];
    int q_cyc[$];

    localparam int EV_DESER = 1;
    localparam int EV_VALID = 2;

`ifdef UART_RX_ERR_FLAGS_EN
    localparam int FLAGS_ON = 1;
`else
    localparam int FLAGS_ON = 0;
`endif

    uart_rx_ctrl #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err), .err_clr(err_clr),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .deser_en(deser_en), .data_valid(data_valid), .busy(busy),
        .par_err_flag(par_err_flag), .stp_err_flag(stp_err_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic pop_event(input int kind);
        int ek, ec;
        if (q_kind.size() == 0) begin
            chk(kind == EV_DESER ? "unexpected_deser_en" : "unexpected_data_valid", cyc, -1);
        end else begin
            ek = q_kind.pop_front();
            ec = q_cyc.pop_front();
            chk("event_kind", kind, ek);
            chk("event_cycle", cyc, ec);
        end
    endtask

    always @(negedge clk) begin
        if (deser_en === 1'b1)   pop_event(EV_DESER);
        if (data_valid === 1'b1) pop_event(EV_VALID);
    end

    function automatic int all_outs();
        return int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                     deser_en, data_valid, busy, par_err_flag, stp_err_flag});
    endfunction

    task automatic idle(input int k);
        rx_in = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    // Drives one 0xA5 frame starting at the current negedge; abort>0 pulls rst at that relative cycle.
    task automatic frame(input int n, input bit par, input bit glitch, input bit perr,
                         input bit serr, input int abort);
        int c0, len, last;
        logic [7:0] d;
        d    = 8'hA5;
        c0   = cyc;
        len  = n * (par ? 11 : 10);
        last = glitch ? n + 1 : (abort > 0 ? abort : len);
        if (!glitch) begin
            for (int k = 0; k < 8; k++)
                if (n * (k + 2) <= last) begin
                    q_kind.push_back(EV_DESER);
                    q_cyc.push_back(c0 + n * (k + 2));
                end
            if (abort == 0 && !perr && !serr) begin
                q_kind.push_back(EV_VALID);
                q_cyc.push_back(c0 + len + 1);
            end
        end
        prescale = 6'(n);
        par_en   = par;
        for (int r = 0; r <= last; r++) begin
            if (r < n)                rx_in = 1'b0;
            else if (glitch)          rx_in = 1'b1;
            else if (r < 9 * n)       rx_in = d[(r - n) / n];
            else if (par && r < 10*n) rx_in = ^d;
            else                      rx_in = 1'b1;
            if (r == 1) begin
                prescale = 6'd3;
                par_en   = !par;
            end
            strt_glitch = glitch && (r == n);
            par_err     = perr && (r == 10 * n);
            stp_err     = serr && (r == len);
            if (abort > 0 && r == abort) rst = 1'b0;
            if (r == 1) begin
                chk("busy_in_start", int'(busy), 1);
                chk("strt_chk_en", int'(strt_chk_en), 1);
            end
            if (r == n) chk("edge_cnt_at_bit_end", int'(edge_cnt), n - 1);
            if (!glitch && r == 2 * n + 1) chk("bit_cnt_bit1", int'(bit_cnt), 1);
            if (!glitch && r == 9 * n)     chk("par_chk_en_before", int'(par_chk_en), 0);
            if (!glitch && r == 9 * n + 1 && r <= last) chk("par_chk_en_first", int'(par_chk_en), int'(par));
            if (!glitch && par && r == 10 * n && r <= last) chk("par_chk_en_last", int'(par_chk_en), 1);
            if (!glitch && abort == 0 && r == len) chk("stp_chk_en", int'(stp_chk_en), 1);
            if (glitch && r == n + 1) begin
                chk("glitch_busy", int'(busy), 0);
                chk("glitch_samp_en", int'(dat_samp_en), 0);
            end
            if (perr && r == 10 * n + 1) chk("par_flag_set", int'(par_err_flag), FLAGS_ON);
            @(negedge clk);
        end
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        rx_in       = 1'b1;
        if (abort > 0) begin
            chk("outputs_after_reset", all_outs(), 0);
            rst = 1'b1;
        end else if (!glitch) begin
            chk("busy_after_stop", int'(busy), 0);
        end
    endtask

    initial begin
        rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; strt_glitch = 1'b0;
        par_err = 1'b0; stp_err = 1'b0; err_clr = 1'b0; prescale = 6'd8;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b1;
        idle(2);
        chk("idle_outputs", all_outs(), 0);

        frame(8, 0, 0, 0, 0, 0);  idle(5);
        frame(8, 1, 0, 0, 0, 0);  idle(5);
        frame(32, 0, 0, 0, 0, 0); idle(5);
        frame(16, 0, 1, 0, 0, 0); idle(5);

        frame(8, 1, 0, 1, 0, 0);
        idle(3);
        chk("par_flag_hold", int'(par_err_flag), FLAGS_ON);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        chk("par_flag_clear", int'(par_err_flag), 0);

        frame(8, 0, 0, 0, 1, 0);
        chk("stp_flag_set", int'(stp_err_flag), FLAGS_ON);
        idle(2);
        chk("stp_flag_hold", int'(stp_err_flag), FLAGS_ON);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        chk("stp_flag_clear", int'(stp_err_flag), 0);
        idle(4);

        frame(8, 0, 0, 0, 0, 0);
        frame(8, 0, 0, 0, 0, 0);
        frame(8, 0, 0, 0, 0, 40);
        idle(100);

        chk("scoreboard_drained", q_kind.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
